// File: rtl/uart_link_bridge.sv
// uart_link_bridge: UART transceiver between board pins and a byte-stream
// interface. 16x oversampled RX with 2-flop synchroniser, framed TX, and
// independent first-word-fall-through FIFOs on both directions.
//
// Optional feature macro: UART_PARITY_EN (adds one even-parity bit to TX and
// RX frames; RX parity mismatch discards the byte and pulses rx_frame_err).
//
// Ports:
//   clock, reset       system clock, asynchronous active-low reset
//   uartRx / uartTx    serial line in / out (idle high)
//   tx_data/tx_valid/tx_ready          TX FIFO write side
//   rx_data/rx_valid/rx_ready          RX FIFO read side (rx_data = head)
//   rx_frame_err, rx_overrun           single-cycle status pulses
//   tx_level, rx_level                 FIFO occupancy

// Synchronous FIFO, pointers carry an extra wrap bit to distinguish full/empty.
module uart_link_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign in_ready  = !full;
    assign out_valid = !empty;
    // Head is forced to zero while empty so the output is defined after reset.
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign level     = wr_ptr - rd_ptr;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (in_valid && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (out_ready && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (in_valid && !full)
            mem[wr_ptr[AW-1:0]] <= in_data;
    end
endmodule

module uart_link_bridge #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          uartRx,
    output logic                          uartTx,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_frame_err,
    output logic                          rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level
);
    localparam int unsigned DIV_RAW = CLK_FREQ_HZ / (BAUD * 16);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;

    // Reset asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_q;
    logic       rst_n;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rst_q <= '0;
        else        rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_n = rst_q[1];

    // 16x oversampling tick
    logic [CW-1:0] div_cnt;
    logic          tick;
    assign tick = (div_cnt == CW'(DIV - 1));
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else        div_cnt <= tick ? '0 : div_cnt + CW'(1);
    end

    // RX synchroniser; rx_prev gives edge detection on the synchronised line
    logic rx_m, rx_s, rx_prev;
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= uartRx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    // ---------------- RX ----------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    rx_state_t            rx_state;
    logic [3:0]           rx_tcnt;
    logic [3:0]           rx_bitcnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_push;
    logic                 rx_in_ready;
`ifdef UART_PARITY_EN
    logic                 rx_par_err;
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_state     <= RX_IDLE;
            rx_tcnt      <= '0;
            rx_bitcnt    <= '0;
            rx_shift     <= '0;
            rx_push      <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_err   <= 1'b0;
`endif
        end else begin
            rx_push      <= 1'b0;
            rx_frame_err <= 1'b0;
            // Push was registered last cycle; it is dropped if the FIFO was full.
            rx_overrun   <= rx_push && !rx_in_ready;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        rx_tcnt  <= '0;
                    end
                end
                RX_START: if (tick) begin
                    if (rx_tcnt == 4'd7) begin
                        rx_tcnt   <= '0;
                        rx_bitcnt <= '0;
                        rx_state  <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                    end
                end
                RX_DATA: if (tick) begin
                    if (rx_tcnt == 4'd15) begin
                        rx_tcnt   <= '0;
                        rx_shift  <= {rx_s, rx_shift[DATA_BITS-1:1]};
                        rx_bitcnt <= rx_bitcnt + 4'd1;
                        if (rx_bitcnt == 4'(DATA_BITS - 1))
`ifdef UART_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                    end else begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: if (tick) begin
                    if (rx_tcnt == 4'd15) begin
                        rx_tcnt    <= '0;
                        rx_par_err <= (^rx_shift) ^ rx_s;
                        rx_state   <= RX_STOP;
                    end else begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                    end
                end
`endif
                RX_STOP: if (tick) begin
                    if (rx_tcnt == 4'd15) begin
                        rx_tcnt  <= '0;
                        rx_state <= RX_IDLE;
`ifdef UART_PARITY_EN
                        if (!rx_s || rx_par_err)
`else
                        if (!rx_s)
`endif
                            rx_frame_err <= 1'b1;
                        else
                            rx_push <= 1'b1;
                    end else begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    uart_link_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_data   (rx_shift),
        .in_valid  (rx_push),
        .in_ready  (rx_in_ready),
        .out_data  (rx_data),
        .out_valid (rx_valid),
        .out_ready (rx_ready),
        .level     (rx_level)
    );

    // ---------------- TX ----------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    tx_state_t            tx_state;
    logic [3:0]           tx_tcnt;
    logic [3:0]           tx_bitcnt;
    logic                 tx_stopcnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_head_valid;
    logic                 tx_pop;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    // Pop when idle, or at the end of the last stop bit so frames run back to back.
    assign tx_pop = tx_head_valid &&
                    ((tx_state == TX_IDLE) ||
                     ((tx_state == TX_STOP) && tick && (tx_tcnt == 4'd15) &&
                      (tx_stopcnt == 1'(STOP_BITS - 1))));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tx_state   <= TX_IDLE;
            tx_tcnt    <= '0;
            tx_bitcnt  <= '0;
            tx_stopcnt <= 1'b0;
            tx_shift   <= '0;
            uartTx     <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par     <= 1'b0;
`endif
        end else if (tx_pop) begin
            tx_shift <= tx_head;
            tx_tcnt  <= '0;
            tx_state <= TX_START;
            uartTx   <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_head;
`endif
        end else begin
            case (tx_state)
                TX_IDLE: uartTx <= 1'b1;
                TX_START: if (tick) begin
                    if (tx_tcnt == 4'd15) begin
                        tx_tcnt   <= '0;
                        tx_bitcnt <= '0;
                        uartTx    <= tx_shift[0];
                        tx_shift  <= tx_shift >> 1;
                        tx_state  <= TX_DATA;
                    end else begin
                        tx_tcnt <= tx_tcnt + 4'd1;
                    end
                end
                TX_DATA: if (tick) begin
                    if (tx_tcnt == 4'd15) begin
                        tx_tcnt <= '0;
                        if (tx_bitcnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            uartTx   <= tx_par;
                            tx_state <= TX_PARITY;
`else
                            uartTx     <= 1'b1;
                            tx_stopcnt <= 1'b0;
                            tx_state   <= TX_STOP;
`endif
                        end else begin
                            uartTx    <= tx_shift[0];
                            tx_shift  <= tx_shift >> 1;
                            tx_bitcnt <= tx_bitcnt + 4'd1;
                        end
                    end else begin
                        tx_tcnt <= tx_tcnt + 4'd1;
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: if (tick) begin
                    if (tx_tcnt == 4'd15) begin
                        tx_tcnt    <= '0;
                        uartTx     <= 1'b1;
                        tx_stopcnt <= 1'b0;
                        tx_state   <= TX_STOP;
                    end else begin
                        tx_tcnt <= tx_tcnt + 4'd1;
                    end
                end
`endif
                TX_STOP: if (tick) begin
                    if (tx_tcnt == 4'd15) begin
                        tx_tcnt <= '0;
                        if (tx_stopcnt == 1'(STOP_BITS - 1))
                            tx_state <= TX_IDLE;
                        else
                            tx_stopcnt <= tx_stopcnt + 1'b1;
                    end else begin
                        tx_tcnt <= tx_tcnt + 4'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    uart_link_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_data   (tx_data),
        .in_valid  (tx_valid),
        .in_ready  (tx_ready),
        .out_data  (tx_head),
        .out_valid (tx_head_valid),
        .out_ready (tx_pop),
        .level     (tx_level)
    );
endmodule
